// File: rtl/hamming_tx.sv
// hamming_tx: byte-in, Hamming(12,8)-encoded serial frame out.
// The codeword bit layout matches the companion 12-bit decoder so code_word
// can be looped straight back into it. err_pos optionally flips one code bit.
//
// state | meaning
// IDLE  | line high, data_ready high, waiting for a byte
// START | start bit (0) held for CLKS_PER_BIT cycles
// DATA  | code bits 0..11, LSB first, each CLKS_PER_BIT cycles
// STOP  | stop bit (1) held for CLKS_PER_BIT cycles
module hamming_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic [3:0]  err_pos,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [11:0] code_word,
  output logic        code_valid,
  output logic        tx,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [3:0]  bit_idx, bit_nxt;
  logic        tx_nxt, busy_nxt, ready_nxt, cv_nxt;
  logic [11:0] code_nxt;
  logic        last_cycle;
  logic        accept;

  // Parity bits cover the positions whose 1-based index has that bit set;
  // the optional flip is applied after encoding so the decoder sees a real
  // single-bit error.
  function automatic logic [11:0] encode(input logic [7:0] d, input logic [3:0] e);
    logic [11:0] cw;
    logic        c0, c1, c2, c3;
    c0 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c1 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c2 = d[1] ^ d[2] ^ d[3] ^ d[7];
    c3 = d[4] ^ d[5] ^ d[6] ^ d[7];
    cw = {d[7], d[6], d[5], d[4], c3, d[3], d[2], d[1], c2, d[0], c1, c0};
    if (e >= 4'd1 && e <= 4'd12) begin
      cw[e - 4'd1] = ~cw[e - 4'd1];
    end
    return cw;
  endfunction

  assign last_cycle = (cnt == LAST_CNT);
  assign accept     = data_valid && data_ready;

  // State and all outputs are registered so tx never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      bit_idx    <= 4'd0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      data_ready <= 1'b0;
      code_valid <= 1'b0;
      code_word  <= 12'h000;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_nxt;
      tx         <= tx_nxt;
      busy       <= busy_nxt;
      data_ready <= ready_nxt;
      code_valid <= cv_nxt;
      code_word  <= code_nxt;
    end
  end

  // Next-state and next-output decode; counters clear on every state entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 8'd1;
    bit_nxt   = bit_idx;
    tx_nxt    = tx;
    busy_nxt  = busy;
    ready_nxt = data_ready;
    code_nxt  = code_word;
    cv_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt   = 8'd0;
        bit_nxt   = 4'd0;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
        ready_nxt = 1'b1;
        if (accept) begin
          state_nxt = START;
          code_nxt  = encode(data_in, err_pos);
          cv_nxt    = 1'b1;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b0;
        end
      end
      START: begin
        if (last_cycle) begin
          state_nxt = DATA;
          cnt_nxt   = 8'd0;
          bit_nxt   = 4'd0;
          tx_nxt    = code_word[0];
        end
      end
      DATA: begin
        if (last_cycle) begin
          cnt_nxt = 8'd0;
          if (bit_idx == 4'd11) begin
            state_nxt = STOP;
            bit_nxt   = 4'd0;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt = bit_idx + 4'd1;
            tx_nxt  = code_word[bit_idx + 4'd1];
          end
        end
      end
      STOP: begin
        if (last_cycle) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
          ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
        bit_nxt   = 4'd0;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
        ready_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_hamming_tx.sv
// Directed bench for hamming_tx: table of encode vectors plus hand-written
// back-to-back and mid-frame reset sequences.
module tb_hamming_tx;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic [3:0]  err_pos;
  logic        data_valid;
  logic        data_ready;
  logic [11:0] code_word;
  logic        code_valid;
  logic        tx;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t_acc = 0;

  hamming_tx #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .err_pos    (err_pos),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .code_word  (code_word),
    .code_valid (code_valid),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  d;
    logic [3:0]  e;
    logic [11:0] code;
    logic [3:0]  syn;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference decoder: syndrome over 1-based positions, correct, extract data.
  function automatic void decode(input logic [11:0] cw_in, output logic [3:0] syn,
                                 output logic [7:0] d);
    logic [11:0] cw;
    cw  = cw_in;
    syn = 4'd0;
    for (int p = 1; p <= 12; p++) begin
      for (int b = 0; b < 4; b++) begin
        if (p[b]) syn[b] = syn[b] ^ cw[p-1];
      end
    end
    if (syn >= 4'd1 && syn <= 4'd12) cw[syn - 4'd1] = ~cw[syn - 4'd1];
    d = {cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
  endfunction

  // Present a byte from a negedge and return right after the accepting posedge.
  task automatic send(input logic [7:0] d, input logic [3:0] e);
    int waited;
    data_in    = d;
    err_pos    = e;
    data_valid = 1'b1;
    waited     = 0;
    while (!data_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!data_ready) begin
      chk("ready_timeout", 0, 1);
    end else begin
      @(posedge clk);
    end
  endtask

  // Check a full frame cycle by cycle, starting just after the accept edge.
  // Ends at the negedge of the last stop-bit cycle.
  task automatic check_frame(input logic [11:0] exp, input bit keep_valid,
                             input logic [7:0] nd, input logic [3:0] ne,
                             output logic [11:0] seen);
    logic exp_bit, slot_ok, bad_tx, cw_ok, ctl_ok;
    logic [11:0] bad_cw;
    exp_bit = 1'b0;
    slot_ok = 1'b1;
    bad_tx  = 1'b0;
    cw_ok   = 1'b1;
    ctl_ok  = 1'b1;
    bad_cw  = exp;
    seen    = 12'h000;
    for (int i = 0; i < 14 * N; i++) begin
      int s;
      @(negedge clk);
      s = i / N;
      if (i == 0) begin
        t_acc = cyc;
        seen  = code_word;
        chk("code_valid_pulse", int'(code_valid), 1);
        chk("code_word_load", int'(code_word), int'(exp));
        if (keep_valid) begin
          data_in = nd;
          err_pos = ne;
        end else begin
          data_valid = 1'b0;
        end
      end else begin
        if (code_valid) ctl_ok = 1'b0;
      end
      if (code_word != exp) begin
        cw_ok  = 1'b0;
        bad_cw = code_word;
      end
      if (!busy || data_ready) ctl_ok = 1'b0;
      if (i % N == 0) begin
        slot_ok = 1'b1;
        exp_bit = (s == 0) ? 1'b0 : (s == 13) ? 1'b1 : exp[s-1];
      end
      if (tx !== exp_bit) begin
        slot_ok = 1'b0;
        bad_tx  = tx;
      end
      if (i % N == N - 1) begin
        chk($sformatf("tx_slot%0d", s), int'(slot_ok ? exp_bit : bad_tx), int'(exp_bit));
      end
    end
    chk("code_word_hold", int'(cw_ok ? exp : bad_cw), int'(exp));
    chk("busy_ready_cv_in_frame", int'(ctl_ok), 1);
  endtask

  // Checks at the first cycle after the frame (edge T+14N).
  task automatic check_idle_after;
    @(negedge clk);
    chk("ready_after_frame", int'(data_ready), 1);
    chk("busy_after_frame", int'(busy), 0);
    chk("tx_idle_after_frame", int'(tx), 1);
    chk("ready_latency", cyc - t_acc, 14 * N);
  endtask

  initial begin
    logic [11:0] seen;
    logic [3:0]  syn;
    logic [7:0]  dd;
    int          t_first;

    vecs[0]  = '{8'hA5, 4'd0,  12'hA27, 4'd0};
    vecs[1]  = '{8'h00, 4'd0,  12'h000, 4'd0};
    vecs[2]  = '{8'hFF, 4'd0,  12'hF77, 4'd0};
    vecs[3]  = '{8'hA5, 4'd5,  12'hA37, 4'd5};
    vecs[4]  = '{8'hA5, 4'd14, 12'hA27, 4'd0};
    vecs[5]  = '{8'h3C, 4'd0,  12'h362, 4'd0};
    vecs[6]  = '{8'hC3, 4'd0,  12'hC15, 4'd0};
    vecs[7]  = '{8'h5A, 4'd0,  12'h550, 4'd0};
    vecs[8]  = '{8'hA5, 4'd12, 12'h227, 4'd12};
    vecs[9]  = '{8'hA5, 4'd1,  12'hA26, 4'd1};
    vecs[10] = '{8'hA5, 4'd13, 12'hA27, 4'd0};
    vecs[11] = '{8'hA5, 4'd15, 12'hA27, 4'd0};

    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    err_pos    = 4'd0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", int'(tx), 1);
      chk("rst_ready", int'(data_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_code_word", int'(code_word), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", int'(data_ready), 1);
    chk("tx_after_release", int'(tx), 1);

    for (int v = 0; v < 12; v++) begin
      send(vecs[v].d, vecs[v].e);
      check_frame(vecs[v].code, 1'b0, 8'h00, 4'd0, seen);
      decode(seen, syn, dd);
      chk($sformatf("dec_syn_v%0d", v), int'(syn), int'(vecs[v].syn));
      chk($sformatf("dec_data_v%0d", v), int'(dd), int'(vecs[v].d));
      check_idle_after();
    end

    // Back-to-back with data_valid held: the second byte waits for data_ready.
    send(8'h3C, 4'd0);
    check_frame(12'h362, 1'b1, 8'hC3, 4'd0, seen);
    t_first = t_acc;
    check_idle_after();
    send(8'hC3, 4'd0);
    check_frame(12'hC15, 1'b0, 8'h00, 4'd0, seen);
    chk("b2b_spacing", t_acc - t_first, 14 * N + 1);
    check_idle_after();

    // Reset during code bit 6 (slot 7) of 0xA5, where tx is 0.
    send(8'hA5, 4'd0);
    repeat (7 * N + 2) begin
      @(negedge clk);
      data_valid = 1'b0;
    end
    chk("pre_reset_tx_bit6", int'(tx), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_code_word", int'(code_word), 0);
    chk("midrst_ready", int'(data_ready), 0);
    chk("midrst_code_valid", int'(code_valid), 0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_tx_held", int'(tx), 1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midrst", int'(data_ready), 1);
    send(8'h5A, 4'd0);
    check_frame(12'h550, 1'b0, 8'h00, 4'd0, seen);
    check_idle_after();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hamming_tx.md
# hamming_tx

Upstream companion to the 12-bit Hamming decoder: accepts 8-bit data bytes over a valid/ready handshake, encodes each into a 12-bit Hamming codeword using the decoder's bit layout, and shifts it out as a framed serial bitstream. It also presents the registered codeword in parallel for loopback into the decoder. An optional per-byte error-injection position lets benches exercise the decoder's single-bit correction path.

## Interface

- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1–255.
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  8  byte to encode; sampled on accept.
- err_pos  input  4  sampled with data_in; 1–12 flips code bit err_pos-1; 0 or 13–15 means no flip.
- data_valid  input  1  upstream byte valid.
- data_ready  output  1  block can accept a byte.
- code_word  output  12  registered codeword of the current frame, including any injected flip.
- code_valid  output  1  one-cycle strobe when code_word updates.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is being sent (START/DATA/STOP).

## Operation

- Encoding, d = data_in, layout code[11:0] = {d7,d6,d5,d4,c3,d3,d2,d1,c2,d0,c1,c0}:
  - c0 = d0^d1^d3^d4^d6; c1 = d0^d2^d3^d5^d6; c2 = d1^d2^d3^d7; c3 = d4^d5^d6^d7.
  - After encoding, code[err_pos-1] is inverted when err_pos is 1–12.
- Accept: data_valid && data_ready on a rising edge. data_in and err_pos are not sampled at any other time.
- FSM states:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 12 bits.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- Frame format: start bit 0, then code[0] through code[11] (LSB first), then stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- Counters: cycle counter 0..CLKS_PER_BIT-1; bit index 0..11. Both clear on entry to each state.
- data_ready is registered and high only in IDLE. While data_ready is low, data_valid is ignored; upstream must hold its byte.
- Reset asserted at any time, including mid-frame, immediately forces:
  - state IDLE, tx=1, data_ready=0, busy=0, code_valid=0, code_word=12'h000, counters 0.
  - The partial frame is abandoned and no stop bit is sent.

## Timing

- Reset values: tx=1, data_ready=0, busy=0, code_valid=0, code_word=0.
- data_ready rises on the first rising edge after rst_n deasserts.
- Accept at edge T. At edge T:
  - code_word loads; code_valid=1 for cycle T..T+1.
  - tx=0 (start bit); busy=1; data_ready=0.
- Bit k of the codeword occupies cycles T+(k+1)·N through T+(k+2)·N-1, where N=CLKS_PER_BIT. Stop bit starts at T+13·N.
- At edge T+14·N: state IDLE, busy=0, data_ready=1, tx=1.
- Earliest next accept is edge T+14·N+1, so minimum frame-to-frame spacing is 14·N+1 cycles.
- tx is driven from a register (glitch-free). code_word holds its value until the next accept.

## Test plan

- Reset then idle: hold rst_n=0 for 3 cycles, release -> tx=1 throughout; data_ready=0 during reset and 1 one edge after release; busy=0; code_word=0x000.
- Encode 0xA5, err_pos=0, N=4 -> code_word=0xA27, one code_valid pulse.
  - tx sequence per 4-cycle bit: 0, 1,1,1,0,0,1,0,0,0,1,0,1, then 1.
  - data_ready returns 56 cycles after accept.
- Corner data: 0x00 -> 0x000; 0xFF -> 0xF77. Feeding each code_word to the decoder returns the original byte with syndrome 0.
- Error injection: 0xA5 with err_pos=5 -> code_word=0xA37; decoder returns 0xA5 with syndrome 5. err_pos=14 -> 0xA27 (no flip).
- Back-to-back with data_valid held high: bytes 0x3C then 0xC3 -> two contiguous frames with exactly one idle-high cycle between stop and start; second byte not sampled before data_ready rises.
- Reset mid-frame: pull rst_n low during bit 6 -> tx=1 immediately, busy=0, code_word=0x000. After release, a new byte 0x5A is framed correctly from its start bit.
